// File: rtl/add_4bit_serial_if.sv
// Handshake and result bus of the bit-serial adder.
// The master side requests an add; the slave side (the adder) returns the flags.
interface add_4bit_serial_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Y;
   logic             C;
   logic             V;
   logic             Z;

   modport master (
      output start, A, B, cin,
      input  busy, done, Y, C, V, Z
   );

   modport slave (
      input  start, A, B, cin,
      output busy, done, Y, C, V, Z
   );
endinterface

// File: rtl/add_4bit_serial.sv
// Bit-serial adder: one full-adder stage plus a registered carry, LSB first.
// It computes Y = A + B + cin and the C/V/Z flags over WIDTH clock cycles.
// Operands are captured at accept. Result registers update only on entry to DONE.
module add_4bit_serial #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   add_4bit_serial_if.slave   bus
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               accept;
   logic               last_bit;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic               carry;
   logic [IDX_W-1:0]   idx;
   logic [WIDTH-1:0]   sum_sr;

   logic               sum_bit;
   logic               cout_bit;
   logic [WIDTH-1:0]   y_final;

   logic [WIDTH-1:0]   y_reg;
   logic               c_reg;
   logic               v_reg;
   logic               z_reg;

   // State register; reset wins over any pending start.
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode and handshake outputs.
   // NOTE: every signal driven here receives a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            bus.busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Single full-adder stage on the current bit, plus the fully assembled sum
   // that becomes visible once the MSB is shifted in.
   always_comb begin
      sum_bit  = a_reg[idx] ^ b_reg[idx] ^ carry;
      cout_bit = (a_reg[idx] & b_reg[idx]) | (carry & (a_reg[idx] ^ b_reg[idx]));
      last_bit = (idx == IDX_W'(WIDTH - 1));
      y_final  = {sum_bit, sum_sr[WIDTH-1:1]};
   end

   // Operand capture, serial datapath and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         sum_sr <= '0;
         y_reg  <= '0;
         c_reg  <= 1'b0;
         v_reg  <= 1'b0;
         z_reg  <= 1'b0;
      end else if (accept) begin
         a_reg  <= bus.A;
         b_reg  <= bus.B;
         carry  <= bus.cin;
         idx    <= '0;
         sum_sr <= '0;
      end else if (state == SHIFT) begin
         carry  <= cout_bit;
         sum_sr <= y_final;
         idx    <= idx + IDX_W'(1);
         if (last_bit) begin
            y_reg <= y_final;
            c_reg <= cout_bit;
            // Same-sign operands whose sum flips sign overflowed.
            v_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_bit != a_reg[WIDTH-1]);
            z_reg <= (y_final == '0);
         end
      end
   end

   assign bus.Y = y_reg;
   assign bus.C = c_reg;
   assign bus.V = v_reg;
   assign bus.Z = z_reg;

endmodule

// File: tb/tb_add_4bit_serial.sv
// Directed self-checking bench for the bit-serial adder at WIDTH=4.
// Inputs are driven 1 time unit after the rising edge, and outputs are observed at that point.
module tb_add_4bit_serial;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   n;

   add_4bit_serial_if #(.WIDTH(4)) bus ();

   add_4bit_serial #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request and advance through the accepting edge.
   task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic ci);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.cin   = ci;
      tick();
      bus.start = 1'b0;
   endtask

   // Called just after the accepting edge. Counts the edges until done,
   // and checks busy and the held result on every cycle before done.
   task automatic wait_done(input string tag, input logic [3:0] held_y, output int edges);
      edges = 0;
      while (bus.done !== 1'b1 && edges < 20) begin
         check({tag, "_busy"}, bus.busy, 1'b1);
         check({tag, "_hold"}, bus.Y, held_y);
         tick();
         edges++;
      end
      check({tag, "_lat"}, edges, 4);
   endtask

   task automatic check_res(input string tag, input logic [3:0] y, input logic c,
                            input logic v, input logic z);
      check({tag, "_Y"}, bus.Y, y);
      check({tag, "_C"}, bus.C, c);
      check({tag, "_V"}, bus.V, v);
      check({tag, "_Z"}, bus.Z, z);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.cin   = 1'b0;
      tick();
      tick();
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check_res("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      // 1: 5 + 3 = 8. The sign flips from positive, so the add overflows.
      launch(4'b0101, 4'b0011, 1'b0);
      wait_done("t1", 4'b0000, n);
      check("t1_busy_at_done", bus.busy, 1'b0);
      check_res("t1", 4'b1000, 1'b0, 1'b1, 1'b0);
      tick();
      check("t1_done_pulse", bus.done, 1'b0);
      check("t1_idle", bus.busy, 1'b0);
      check("t1_keep_Y", bus.Y, 4'b1000);

      // 2: 15 + 1 wraps to 0 with carry-out.
      launch(4'b1111, 4'b0001, 1'b0);
      wait_done("t2", 4'b1000, n);
      check_res("t2", 4'b0000, 1'b1, 1'b0, 1'b1);
      tick();

      // 3: rebuild the minuend: 3 + 9 + 1 = 13.
      launch(4'b0011, 4'b1001, 1'b1);
      wait_done("t3a", 4'b0000, n);
      check_res("t3a", 4'b1101, 1'b0, 1'b0, 1'b0);
      tick();
      launch(4'b0000, 4'b0000, 1'b0);
      wait_done("t3b", 4'b1101, n);
      check_res("t3b", 4'b0000, 1'b0, 1'b0, 1'b1);
      tick();

      // 4: a start during SHIFT is ignored and the operand pins are isolated.
      launch(4'b0001, 4'b0001, 1'b0);
      tick();
      tick();
      check("t4_mid_busy", bus.busy, 1'b1);
      bus.start = 1'b1;
      bus.A     = 4'b1111;
      bus.B     = 4'b1111;
      bus.cin   = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 3;
      while (bus.done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("t4_lat", n, 4);
      check_res("t4", 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      check("t4_single_done", bus.done, 1'b0);
      check("t4_no_requeue", bus.busy, 1'b0);
      tick();

      // 5: back-to-back. The second start is taken in the done cycle.
      launch(4'b0111, 4'b0001, 1'b0);
      wait_done("t5a", 4'b0010, n);
      check_res("t5a", 4'b1000, 1'b0, 1'b1, 1'b0);
      launch(4'b1000, 4'b1000, 1'b0);
      check("t5_no_idle", bus.busy, 1'b1);
      wait_done("t5b", 4'b1000, n);
      check_res("t5b", 4'b0000, 1'b1, 1'b1, 1'b1);
      tick();

      // 6: reset mid-operation aborts the add and clears the outputs.
      launch(4'b0101, 4'b0011, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy", bus.busy, 1'b0);
      check("t6_done", bus.done, 1'b0);
      check_res("t6", 4'b0000, 1'b0, 1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done === 1'b1) n++;
      end
      check("t6_no_done", n, 0);
      launch(4'b0010, 4'b0011, 1'b1);
      wait_done("t6f", 4'b0000, n);
      check_res("t6f", 4'b0110, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
